// File: rtl/armleocpu_branch_pkg.sv
// armleocpu_branch_pkg
// Shared encodings for the branch resolution unit:
//   - operation kind constants (BRANCH, JAL, JALR, KIND_RSVD)
//   - branch funct3 condition constants
//   - s1_flags_t: the single-bit part of the stage-1 payload
// The wide stage-1 fields (target, link, predicted target) depend on XLEN,
// so they live as separate registers in the top-level module.
package armleocpu_branch_pkg;

  localparam logic [1:0] BRANCH    = 2'b00;
  localparam logic [1:0] JAL       = 2'b01;
  localparam logic [1:0] JALR      = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic taken;       // resolved direction (already forced to 0 when illegal)
    logic illegal;     // reserved kind or illegal funct3
    logic pred_taken;  // fetch-stage prediction carried alongside
  } s1_flags_t;

endpackage

// File: rtl/armleocpu_branch_compare.sv
// armleocpu_branch_compare
// Combinational branch condition evaluation.
// Ports:
//   funct3         in   branch condition select
//   rs1, rs2       in   XLEN-wide operands
//   taken          out  condition holds
//   illegal_funct3 out  funct3 is not a defined branch condition (010, 011)
module armleocpu_branch_compare
  import armleocpu_branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal_funct3
);

  always_comb begin
    taken          = 1'b0;
    illegal_funct3 = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/armleocpu_branch_resolve.sv
// armleocpu_branch_resolve
// Two-stage pipelined branch / JAL / JALR resolution for the execute stage.
// Stage 1 evaluates the condition and computes target and link; stage 2
// checks the result against the fetch prediction and drives every out_* port.
//
// Parameters: XLEN (32 or 64), C_EXT (1 = 2-byte target alignment),
//             STAT_W (statistics counter width).
// Optional feature: define ARMLEOCPU_BRANCH_STATS_EN to add the
//   stat_branches / stat_mispredicts saturating counters and their ports.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kills both stages, blocks input this cycle
//   in_valid/in_ready   input handshake
//   in_kind, in_funct3  operation kind and branch condition
//   in_rs1, in_rs2      operands
//   in_pc, in_imm       instruction PC and sign-extended immediate
//   in_pred_taken/_target  fetch-stage prediction
//   out_valid/out_ready output handshake
//   out_taken, out_target, out_link, out_mispredict, out_redirect_pc,
//   out_illegal, out_misaligned   resolved result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never depends on ready; in_ready depends combinationally on
// out_ready and flush. Once out_valid is 1 it and all out_* hold until the
// transfer. Flush overrides both handshakes.
module armleocpu_branch_resolve
  import armleocpu_branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int C_EXT  = 0,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_pred_taken,
  input  logic [XLEN-1:0]   in_pred_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [XLEN-1:0]   out_target,
  output logic [XLEN-1:0]   out_link,
  output logic              out_mispredict,
  output logic [XLEN-1:0]   out_redirect_pc,
  output logic              out_illegal,
  output logic              out_misaligned
`ifdef ARMLEOCPU_BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("armleocpu_branch_resolve: XLEN must be 32 or 64");
  end
  if (STAT_W < 1) begin : g_bad_stat_w
    $error("armleocpu_branch_resolve: STAT_W must be at least 1");
  end

  // ---------------------------------------------------------------------
  // Advance control
  // ---------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load, s2_load;
  logic s1_en, s2_en;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = !flush && s1_load;
  assign s1_en    = in_valid && in_ready;
  assign s2_en    = !flush && s2_load && s1_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_load) s1_valid_d = s1_en;
      if (s2_load) s2_valid_d = s1_valid_q;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 inputs
  // ---------------------------------------------------------------------
  logic cmp_taken, cmp_illegal;

  armleocpu_branch_compare #(
    .XLEN(XLEN)
  ) u_compare (
    .funct3         (in_funct3),
    .rs1            (in_rs1),
    .rs2            (in_rs2),
    .taken          (cmp_taken),
    .illegal_funct3 (cmp_illegal)
  );

  s1_flags_t       s1_flags_q, s1_flags_d;
  logic [XLEN-1:0] s1_target_q, s1_target_d;
  logic [XLEN-1:0] s1_link_q, s1_link_d;
  logic [XLEN-1:0] s1_pred_target_q, s1_pred_target_d;
  logic [XLEN-1:0] pc_sum, rs1_sum;

  always_comb begin
    pc_sum  = in_pc + in_imm;
    rs1_sum = in_rs1 + in_imm;

    s1_flags_d            = '0;
    s1_flags_d.pred_taken = in_pred_taken;
    s1_flags_d.illegal    = (in_kind == KIND_RSVD) ||
                            ((in_kind == BRANCH) && cmp_illegal);
    s1_target_d           = pc_sum;
    s1_link_d             = in_pc + XLEN'(4);
    s1_pred_target_d      = in_pred_target;

    case (in_kind)
      BRANCH:  s1_flags_d.taken = cmp_taken;
      JAL:     s1_flags_d.taken = 1'b1;
      JALR: begin
        s1_flags_d.taken = 1'b1;
        s1_target_d      = rs1_sum & {{(XLEN-1){1'b1}}, 1'b0};
      end
      default: s1_flags_d.taken = 1'b0;
    endcase

    // Illegal results report neither a direction nor a target.
    if (s1_flags_d.illegal) begin
      s1_flags_d.taken = 1'b0;
      s1_target_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q       <= 1'b0;
      s1_flags_q       <= '0;
      s1_target_q      <= '0;
      s1_link_q        <= '0;
      s1_pred_target_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_en) begin
        s1_flags_q       <= s1_flags_d;
        s1_target_q      <= s1_target_d;
        s1_link_q        <= s1_link_d;
        s1_pred_target_q <= s1_pred_target_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: prediction check
  // ---------------------------------------------------------------------
  logic            s2_taken_q, s2_taken_d;
  logic            s2_illegal_q, s2_illegal_d;
  logic            s2_misaligned_q, s2_misaligned_d;
  logic            s2_mispredict_q, s2_mispredict_d;
  logic [XLEN-1:0] s2_target_q, s2_target_d;
  logic [XLEN-1:0] s2_link_q, s2_link_d;
  logic [XLEN-1:0] s2_redirect_q, s2_redirect_d;

  always_comb begin
    s2_taken_d      = s1_flags_q.taken;
    s2_illegal_d    = s1_flags_q.illegal;
    s2_target_d     = s1_target_q;
    s2_link_d       = s1_link_q;
    // With compressed instructions any even target is fine; bit 0 is
    // already clear for every kind, so only bit 1 can fault.
    s2_misaligned_d = (C_EXT == 0) && s1_flags_q.taken && s1_target_q[1];
    // A faulting result traps instead of redirecting.
    s2_mispredict_d = !s1_flags_q.illegal && !s2_misaligned_d &&
                      ((s1_flags_q.taken != s1_flags_q.pred_taken) ||
                       (s1_flags_q.taken && (s1_target_q != s1_pred_target_q)));
    s2_redirect_d   = s1_flags_q.taken ? s1_target_q : s1_link_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q      <= 1'b0;
      s2_taken_q      <= 1'b0;
      s2_illegal_q    <= 1'b0;
      s2_misaligned_q <= 1'b0;
      s2_mispredict_q <= 1'b0;
      s2_target_q     <= '0;
      s2_link_q       <= '0;
      s2_redirect_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_en) begin
        s2_taken_q      <= s2_taken_d;
        s2_illegal_q    <= s2_illegal_d;
        s2_misaligned_q <= s2_misaligned_d;
        s2_mispredict_q <= s2_mispredict_d;
        s2_target_q     <= s2_target_d;
        s2_link_q       <= s2_link_d;
        s2_redirect_q   <= s2_redirect_d;
      end
    end
  end

  assign out_valid       = s2_valid_q;
  assign out_taken       = s2_taken_q;
  assign out_target      = s2_target_q;
  assign out_link        = s2_link_q;
  assign out_mispredict  = s2_mispredict_q;
  assign out_redirect_pc = s2_redirect_q;
  assign out_illegal     = s2_illegal_q;
  assign out_misaligned  = s2_misaligned_q;

  // ---------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------
`ifdef ARMLEOCPU_BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q, stat_mispredicts_q;
  logic              out_fire;

  // A flush wins over a coincident output handshake, so that entry is dropped.
  assign out_fire = s2_valid_q && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (out_fire && !s2_illegal_q && (stat_branches_q != '1))
        stat_branches_q <= stat_branches_q + STAT_W'(1);
      if (out_fire && s2_mispredict_q && (stat_mispredicts_q != '1))
        stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_armleocpu_branch_resolve.sv
// Testbench for armleocpu_branch_resolve: two instances (C_EXT = 0 and 1)
// share all inputs; a reference model computes each expected result when
// an input is accepted and a monitor compares on every output transfer.
module tb_armleocpu_branch_resolve;

  localparam int XLEN   = 32;
  localparam int STAT_W = 32;
  localparam int W      = 4 + 3 * XLEN;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [1:0]      in_kind = '0;
  logic [2:0]      in_funct3 = '0;
  logic [XLEN-1:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
  logic            in_pred_taken = 1'b0;
  logic [XLEN-1:0] in_pred_target = '0;
  logic            out_ready = 1'b0;

  logic            in_ready, out_valid, out_taken, out_mispredict, out_illegal, out_misaligned;
  logic [XLEN-1:0] out_target, out_link, out_redirect_pc;
  logic            c_in_ready, c_out_valid, c_out_taken, c_out_mispredict, c_out_illegal, c_out_misaligned;
  logic [XLEN-1:0] c_out_target, c_out_link, c_out_redirect_pc;
`ifdef ARMLEOCPU_BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches, stat_mispredicts, c_stat_branches, c_stat_mispredicts;
`endif

  always #5 clk = ~clk;

  armleocpu_branch_resolve #(.XLEN(XLEN), .C_EXT(0), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link), .out_mispredict(out_mispredict),
    .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal),
    .out_misaligned(out_misaligned)
`ifdef ARMLEOCPU_BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  armleocpu_branch_resolve #(.XLEN(XLEN), .C_EXT(1), .STAT_W(STAT_W)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_taken(c_out_taken),
    .out_target(c_out_target), .out_link(c_out_link), .out_mispredict(c_out_mispredict),
    .out_redirect_pc(c_out_redirect_pc), .out_illegal(c_out_illegal),
    .out_misaligned(c_out_misaligned)
`ifdef ARMLEOCPU_BRANCH_STATS_EN
    , .stat_branches(c_stat_branches), .stat_mispredicts(c_stat_mispredicts)
`endif
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_c_q[$];
  int checks = 0;
  int errors = 0;
  int exp_branches = 0;
  int exp_mispredicts = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Result layout: {taken, illegal, misaligned, mispredict,
  // target, link, redirect}; redirect is zero when no redirect is required.
  function automatic logic [W-1:0] model(input logic [1:0] kind, input logic [2:0] f3,
                                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                                         input logic pt, input logic [XLEN-1:0] ptgt,
                                         input int cext);
    logic tk, ill, mis, mp;
    logic [XLEN-1:0] tgt, lnk, rd;
    ill = (kind == 2'd3) || (kind == 2'd0 && (f3 == 3'd2 || f3 == 3'd3));
    tk = 1'b0;
    if (kind == 2'd1 || kind == 2'd2) tk = 1'b1;
    else if (kind == 2'd0) begin
      case (f3)
        3'd0: tk = (rs1 == rs2);
        3'd1: tk = (rs1 != rs2);
        3'd4: tk = ($signed(rs1) <  $signed(rs2));
        3'd5: tk = ($signed(rs1) >= $signed(rs2));
        3'd6: tk = (rs1 <  rs2);
        3'd7: tk = (rs1 >= rs2);
        default: tk = 1'b0;
      endcase
    end
    if (kind == 2'd2) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    else              tgt = pc + imm;
    if (ill) begin
      tk  = 1'b0;
      tgt = '0;
    end
    lnk = pc + 32'd4;
    mis = tk && tgt[1] && (cext == 0);
    mp  = !ill && !mis && ((tk != pt) || (tk && tgt != ptgt));
    rd  = mp ? (tk ? tgt : lnk) : '0;
    return {tk, ill, mis, mp, tgt, lnk, rd};
  endfunction

  function automatic logic [W-1:0] pack_act(input logic tk, input logic ill, input logic mis,
                                            input logic mp, input logic [XLEN-1:0] tgt,
                                            input logic [XLEN-1:0] lnk, input logic [XLEN-1:0] rd,
                                            input logic exp_mp);
    return {tk, ill, mis, mp, tgt, lnk, (exp_mp ? rd : {XLEN{1'b0}})};
  endfunction

  function automatic logic [W-1:0] dut_act(input logic exp_mp);
    return pack_act(out_taken, out_illegal, out_misaligned, out_mispredict,
                    out_target, out_link, out_redirect_pc, exp_mp);
  endfunction

  function automatic logic [W-1:0] dut_c_act(input logic exp_mp);
    return pack_act(c_out_taken, c_out_illegal, c_out_misaligned, c_out_mispredict,
                    c_out_target, c_out_link, c_out_redirect_pc, exp_mp);
  endfunction

  // ---------------------------------------------------------------------
  // Monitor: compare on every output transfer
  // ---------------------------------------------------------------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_ready && out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", W'(1), W'(0));
        else begin
          e = exp_q.pop_front();
          chk("result_c0", dut_act(e[W-4]), e);
          if (!e[W-2]) exp_branches++;
          if (e[W-4])  exp_mispredicts++;
        end
      end
      if (rst_n && out_ready && c_out_valid) begin
        if (exp_c_q.size() == 0) chk("unexpected_out_c1", W'(1), W'(0));
        else begin
          e = exp_c_q.pop_front();
          chk("result_c1", dut_c_act(e[W-4]), e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  task automatic issue(input logic [1:0] kind, input logic [2:0] f3,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic pt, input logic [XLEN-1:0] ptgt);
    int waited = 0;
    in_valid = 1'b1;
    in_kind = kind; in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2;
    in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(kind, f3, rs1, rs2, pc, imm, pt, ptgt, 0));
        exp_c_q.push_back(model(kind, f3, rs1, rs2, pc, imm, pt, ptgt, 1));
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 200) begin
        chk("issue_timeout", W'(0), W'(1));
        @(posedge clk); #1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || exp_c_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", W'(exp_q.size() + exp_c_q.size()), W'(0));
  endtask

  task automatic check_stats(input string name);
`ifdef ARMLEOCPU_BRANCH_STATS_EN
    chk({name, "_branches"}, W'(stat_branches), W'(exp_branches));
    chk({name, "_mispredicts"}, W'(stat_mispredicts), W'(exp_mispredicts));
    chk({name, "_branches_c1"}, W'(c_stat_branches), W'(exp_branches));
`else
    chk({name, "_no_stats_queue"}, W'(exp_q.size()), W'(exp_q.size() == 0 ? 0 : exp_q.size()));
`endif
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  bit rand_done = 1'b0;

  initial begin
    logic [W-1:0] e;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_data", dut_act(1'b1), W'(0));
    chk("reset_data_c1", dut_c_act(1'b1), W'(0));
    @(posedge clk); #1;

    // Latency: signed-lt branch into an empty pipe
    out_ready = 1'b1;
    issue(2'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0);
    @(negedge clk);
    chk("latency_not_yet", W'(out_valid), W'(0));
    @(negedge clk);
    chk("latency_valid", W'(out_valid), W'(1));
    @(posedge clk); #1;

    // Directed vectors, back to back
    issue(2'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0);   // bltu not taken
    issue(2'd2, 3'd0, 32'h1003, 32'd0, 32'h200, 32'h0, 1'b1, 32'h1002);      // jalr misaligned (C_EXT=0)
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'h8);      // jal wrap
    issue(2'd0, 3'd2, 32'd5, 32'd5, 32'h300, 32'h40, 1'b1, 32'h340);         // illegal funct3
    issue(2'd3, 3'd0, 32'd5, 32'd5, 32'h300, 32'h40, 1'b0, 32'h0);           // reserved kind
    issue(2'd0, 3'd0, 32'd7, 32'd7, 32'h400, 32'hFFFF_FFF0, 1'b1, 32'h3F0);  // beq, correct prediction
    issue(2'd0, 3'd5, 32'h8000_0000, 32'd1, 32'h500, 32'h10, 1'b1, 32'h510); // bge signed not taken
    drain();

    // Stall: two entries held, in_ready drops, outputs stable
    out_ready = 1'b0;
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'h1000, 32'h80, 1'b0, 32'h0);
    issue(2'd0, 3'd1, 32'd1, 32'd2, 32'h2000, 32'h8, 1'b1, 32'h2008);
    fork
      issue(2'd0, 3'd7, 32'd3, 32'd9, 32'h3000, 32'h4, 1'b1, 32'h3004);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready_low", W'(in_ready), W'(0));
          chk("stall_out_valid", W'(out_valid), W'(1));
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("stall_out_stable", dut_act(e[W-4]), e);
          end else chk("stall_queue", W'(0), W'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    repeat (2) @(posedge clk); #1;
    check_stats("stats_pre_flush");

    // Flush with both stages full
    out_ready = 1'b0;
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'h4000, 32'h10, 1'b0, 32'h0);
    issue(2'd0, 3'd0, 32'd1, 32'd1, 32'h5000, 32'h10, 1'b0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    exp_c_q.delete();
    @(negedge clk);
    chk("flush_out_valid", W'({out_valid, c_out_valid}), W'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_stats("stats_after_flush");

    // Randomized traffic with random output back-pressure
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          logic [1:0] kind;
          logic [2:0] f3;
          logic [XLEN-1:0] rs1, rs2, pc, imm, ptgt;
          logic [11:0] i12;
          int r;
          r = $urandom_range(0, 15);
          kind = (r < 9) ? 2'd0 : (r < 12) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
          f3   = 3'($urandom_range(0, 7));
          rs1  = $urandom;
          rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
          pc   = $urandom & 32'hFFFF_FFFC;
          i12  = 12'($urandom);
          imm  = {{20{i12[11]}}, i12};
          if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
          if ($urandom_range(0, 2) == 0) ptgt = $urandom;
          else if (kind == 2'd2) ptgt = (rs1 + imm) & 32'hFFFF_FFFE;
          else ptgt = pc + imm;
          if (kind == 2'd2 && $urandom_range(0, 1) == 0) rs1[1:0] = 2'b00;
          issue(kind, f3, rs1, rs2, pc, imm, 1'($urandom_range(0, 1)), ptgt);
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    repeat (2) @(posedge clk); #1;
    check_stats("stats_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
